// File: rtl/csp_ep_pkg.sv
// Shared definitions for the CSP leaf endpoint: packet geometry defaults, FSM encodings, counter widths.
package csp_ep_pkg;

    localparam int unsigned PKT_WIDTH  = 11;
    localparam int unsigned PKT_ADDR_W = 3;
    localparam int unsigned TX_CNT_W   = 16;
    localparam int unsigned RX_CNT_W   = 16;
    localparam int unsigned MIS_CNT_W  = 8;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_RTZ  = 2'd2
    } tx_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/csp_sync_bit.sv
// Multi-flop synchroniser for one asynchronous handshake wire.
module csp_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/csp_leaf_endpoint.sv
// Leaf network interface: host TX FIFO into a 4-phase bundled-data transmitter,
// 4-phase receiver into a one-entry host buffer, plus traffic/misroute counters.
module csp_leaf_endpoint
    import csp_ep_pkg::*;
#(
    parameter int unsigned WIDTH       = PKT_WIDTH,
    parameter int unsigned ADDR_W      = PKT_ADDR_W,
    parameter int unsigned MY_ADDR     = 0,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     host_tx_data,
    input  logic                 host_tx_valid,
    output logic                 host_tx_ready,
    output logic [WIDTH-1:0]     host_rx_data,
    output logic                 host_rx_valid,
    input  logic                 host_rx_ready,
    output logic [WIDTH-1:0]     net_tx_data,
    output logic                 net_tx_req,
    input  logic                 net_tx_ack,
    input  logic [WIDTH-1:0]     net_rx_data,
    input  logic                 net_rx_req,
    output logic                 net_rx_ack,
    output logic [TX_CNT_W-1:0]  tx_count,
    output logic [RX_CNT_W-1:0]  rx_count,
    output logic [MIS_CNT_W-1:0] misroute_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FILL_W = $clog2(FIFO_DEPTH + 1);

    logic             ack_sync;
    logic             req_sync;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [FILL_W-1:0] fill;
    logic             push;
    logic             pop;
    logic             rx_free;
    logic             rx_drain;
    logic [ADDR_W-1:0] rx_dest;
    tx_state_t        tx_state;
    rx_state_t        rx_state;

    csp_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (net_tx_ack),
        .q     (ack_sync)
    );

    csp_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (net_rx_req),
        .q     (req_sync)
    );

    assign host_tx_ready = (fill != FILL_W'(FIFO_DEPTH));
    assign push          = host_tx_valid && host_tx_ready;
    assign pop           = (tx_state == T_IDLE) && (fill != '0);
    assign rx_drain      = host_rx_valid && host_rx_ready;
    assign rx_free       = !host_rx_valid || host_rx_ready;
    assign rx_dest       = net_rx_data[WIDTH-1 -: ADDR_W];

    // FIFO storage is not reset; only pointers and fill define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_tx_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fill <= fill + FILL_W'(1);
            else if (pop && !push) fill <= fill - FILL_W'(1);
        end
    end

    // Transmitter: data is loaded with req and held until the ack has returned to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state    <= T_IDLE;
            net_tx_req  <= 1'b0;
            net_tx_data <= '0;
            tx_count    <= '0;
        end else begin
            case (tx_state)
                T_IDLE: if (pop) begin
                    net_tx_data <= mem[rd_ptr];
                    net_tx_req  <= 1'b1;
                    tx_state    <= T_REQ;
                end
                T_REQ: if (ack_sync) begin
                    net_tx_req <= 1'b0;
                    tx_state   <= T_RTZ;
                end
                T_RTZ: if (!ack_sync) begin
                    tx_count <= tx_count + TX_CNT_W'(1);
                    tx_state <= T_IDLE;
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // Receiver: ack is withheld while the host buffer is occupied, so nothing is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state       <= R_IDLE;
            net_rx_ack     <= 1'b0;
            host_rx_valid  <= 1'b0;
            host_rx_data   <= '0;
            rx_count       <= '0;
            misroute_count <= '0;
        end else begin
            if (rx_drain) host_rx_valid <= 1'b0;
            case (rx_state)
                R_IDLE: if (req_sync && rx_free) begin
                    host_rx_data  <= net_rx_data;
                    host_rx_valid <= 1'b1;
                    net_rx_ack    <= 1'b1;
                    rx_state      <= R_ACK;
                    rx_count      <= rx_count + RX_CNT_W'(1);
                    if (rx_dest != ADDR_W'(MY_ADDR) && misroute_count != '1)
                        misroute_count <= misroute_count + MIS_CNT_W'(1);
                end
                R_ACK: if (!req_sync) begin
                    net_rx_ack <= 1'b0;
                    rx_state   <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csp_leaf_endpoint.sv
// Directed self-checking bench for csp_leaf_endpoint, acting as host and as a zero-logic router.
module tb_csp_leaf_endpoint;

    localparam int unsigned W = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  host_tx_data;
    logic          host_tx_valid;
    logic          host_tx_ready;
    logic [W-1:0]  host_rx_data;
    logic          host_rx_valid;
    logic          host_rx_ready;
    logic [W-1:0]  net_tx_data;
    logic          net_tx_req;
    logic          net_tx_ack;
    logic [W-1:0]  net_rx_data;
    logic          net_rx_req;
    logic          net_rx_ack;
    logic [15:0]   tx_count;
    logic [15:0]   rx_count;
    logic [7:0]    misroute_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [15:0]   exp_tx   = 16'd0;
    logic [15:0]   exp_rx   = 16'd0;

    csp_leaf_endpoint dut (
        .clk            (clk),
        .reset          (reset),
        .host_tx_data   (host_tx_data),
        .host_tx_valid  (host_tx_valid),
        .host_tx_ready  (host_tx_ready),
        .host_rx_data   (host_rx_data),
        .host_rx_valid  (host_rx_valid),
        .host_rx_ready  (host_rx_ready),
        .net_tx_data    (net_tx_data),
        .net_tx_req     (net_tx_req),
        .net_tx_ack     (net_tx_ack),
        .net_rx_data    (net_rx_data),
        .net_rx_req     (net_rx_req),
        .net_rx_ack     (net_rx_ack),
        .tx_count       (tx_count),
        .rx_count       (rx_count),
        .misroute_count (misroute_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_tx_req(input logic v, input string tag);
        int n = 0;
        while (net_tx_req !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(net_tx_req), 32'(v));
    endtask

    task automatic wait_rx_ack(input logic v, input string tag);
        int n = 0;
        while (net_rx_ack !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(net_rx_ack), 32'(v));
    endtask

    task automatic push(input logic [W-1:0] d);
        host_tx_data  = d;
        host_tx_valid = 1'b1;
        @(negedge clk);
        host_tx_valid = 1'b0;
    endtask

    // Router side of one TX handshake; ack raised 'delay' clocks after req is seen.
    task automatic tx_serve(input logic [W-1:0] d, input int delay);
        wait_tx_req(1'b1, "tx_req_rise");
        check("tx_data", 32'(net_tx_data), 32'(d));
        repeat (delay) @(negedge clk);
        net_tx_ack = 1'b1;
        wait_tx_req(1'b0, "tx_req_fall");
        check("tx_data_rtz", 32'(net_tx_data), 32'(d));
        net_tx_ack = 1'b0;
        repeat (4) @(negedge clk);
        exp_tx = exp_tx + 16'd1;
        check("tx_count", 32'(tx_count), 32'(exp_tx));
    endtask

    task automatic rx_send(input logic [W-1:0] d);
        net_rx_data = d;
        @(negedge clk);
        net_rx_req = 1'b1;
        wait_rx_ack(1'b1, "rx_ack_rise");
        net_rx_req = 1'b0;
        wait_rx_ack(1'b0, "rx_ack_fall");
        exp_rx = exp_rx + 16'd1;
    endtask

    initial begin
        reset         = 1'b0;
        host_tx_data  = '0;
        host_tx_valid = 1'b0;
        host_rx_ready = 1'b0;
        net_tx_ack    = 1'b1;
        net_rx_data   = 11'h7FF;
        net_rx_req    = 1'b1;
        repeat (3) @(negedge clk);

        // Reset with router wires held high
        check("rst_tx_req",   32'(net_tx_req), 32'd0);
        check("rst_rx_ack",   32'(net_rx_ack), 32'd0);
        check("rst_tx_data",  32'(net_tx_data), 32'd0);
        check("rst_rx_valid", 32'(host_rx_valid), 32'd0);
        check("rst_rx_data",  32'(host_rx_data), 32'd0);
        check("rst_tx_ready", 32'(host_tx_ready), 32'd1);
        check("rst_counts",   {tx_count, rx_count}, 32'd0);
        check("rst_misroute", 32'(misroute_count), 32'd0);
        net_tx_ack = 1'b0;
        net_rx_req = 1'b0;
        reset      = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_tx_req", 32'(net_tx_req), 32'd0);
        check("idle_rx_ack", 32'(net_rx_ack), 32'd0);

        // Single packet: latency and ordered handshake
        push(11'h155);
        check("tx_latency_pre", 32'(net_tx_req), 32'd0);
        @(negedge clk);
        check("tx_latency", 32'(net_tx_req), 32'd1);
        tx_serve(11'h155, 3);

        // Five back-to-back pushes with ack stalled
        for (int i = 0; i < 5; i++) begin
            check("tx_ready_free", 32'(host_tx_ready), 32'd1);
            host_tx_data  = 11'((i + 1) * 'h101);
            host_tx_valid = 1'b1;
            @(negedge clk);
        end
        host_tx_data = 11'h606;
        check("tx_full", 32'(host_tx_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("tx_full_hold", 32'(host_tx_ready), 32'd0);
        host_tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) tx_serve(11'((i + 1) * 'h101), 1);
        repeat (5) @(negedge clk);
        check("tx_no_extra", 32'(net_tx_req), 32'd0);

        // RX backpressure and same-cycle drain+capture
        net_rx_data = 11'h0AA;
        @(negedge clk);
        net_rx_req = 1'b1;
        wait_rx_ack(1'b1, "rx1_ack_rise");
        exp_rx = exp_rx + 16'd1;
        check("rx1_valid", 32'(host_rx_valid), 32'd1);
        check("rx1_data",  32'(host_rx_data), 32'h0AA);
        check("rx1_count", 32'(rx_count), 32'(exp_rx));
        check("rx1_mis",   32'(misroute_count), 32'd0);
        net_rx_req = 1'b0;
        wait_rx_ack(1'b0, "rx1_ack_fall");
        net_rx_data = 11'h0BB;
        @(negedge clk);
        net_rx_req = 1'b1;
        repeat (8) @(negedge clk);
        check("rx_backpressure", 32'(net_rx_ack), 32'd0);
        check("rx_buf_kept",     32'(host_rx_data), 32'h0AA);
        host_rx_ready = 1'b1;
        @(negedge clk);
        host_rx_ready = 1'b0;
        exp_rx = exp_rx + 16'd1;
        check("rx2_valid", 32'(host_rx_valid), 32'd1);
        check("rx2_data",  32'(host_rx_data), 32'h0BB);
        check("rx2_ack",   32'(net_rx_ack), 32'd1);
        check("rx2_count", 32'(rx_count), 32'(exp_rx));
        net_rx_req = 1'b0;
        wait_rx_ack(1'b0, "rx2_ack_fall");
        host_rx_ready = 1'b1;
        @(negedge clk);
        host_rx_ready = 1'b0;
        check("rx_drained", 32'(host_rx_valid), 32'd0);

        // Misrouted packets (dest 5) are delivered and counted, saturating at 255
        host_rx_ready = 1'b1;
        rx_send(11'h533);
        check("mis_data",  32'(host_rx_data), 32'h533);
        check("mis_one",   32'(misroute_count), 32'd1);
        check("mis_rxcnt", 32'(rx_count), 32'(exp_rx));
        for (int i = 0; i < 253; i++) rx_send(11'h500 | 11'(i & 'hFF));
        check("mis_254", 32'(misroute_count), 32'd254);
        rx_send(11'h5AB);
        check("mis_255", 32'(misroute_count), 32'd255);
        rx_send(11'h5CD);
        check("mis_sat", 32'(misroute_count), 32'd255);
        check("mis_sat_data", 32'(host_rx_data), 32'h5CD);
        check("rx_count_258", 32'(rx_count), 32'd258);
        host_rx_ready = 1'b0;

        // tx_count wrap
        force dut.tx_count = 16'hFFFF;
        @(negedge clk);
        release dut.tx_count;
        @(negedge clk);
        exp_tx = 16'hFFFF;
        check("tx_preset", 32'(tx_count), 32'h0000FFFF);
        push(11'h0F0);
        tx_serve(11'h0F0, 0);
        check("tx_wrap", 32'(tx_count), 32'd0);

        // Reset during T_REQ abandons the handshake
        push(11'h321);
        wait_tx_req(1'b1, "rst_mid_req_rise");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_req",     32'(net_tx_req), 32'd0);
        check("rst_mid_data",    32'(net_tx_data), 32'd0);
        check("rst_mid_counts",  {tx_count, rx_count}, 32'd0);
        check("rst_mid_mis",     32'(misroute_count), 32'd0);
        check("rst_mid_rx_data", 32'(host_rx_data), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_idle", 32'(net_tx_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
